// File: rtl/fir_filter.sv
// fir_filter: AXI-Lite programmed 11-tap FIR over AXI-Stream; define FIR_DONE_CLEAR_ON_READ_EN to clear ap_done on a read of ap_ctrl
module fir_filter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num = 11
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [pADDR_WIDTH-1:0]     awaddr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [pDATA_WIDTH-1:0]     wdata,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [pADDR_WIDTH-1:0]     araddr,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [pDATA_WIDTH-1:0]     rdata,
  input  logic                       ss_tvalid,
  input  logic [pDATA_WIDTH-1:0]     ss_tdata,
  input  logic                       ss_tlast,
  output logic                       ss_tready,
  output logic                       sm_tvalid,
  output logic [pDATA_WIDTH-1:0]     sm_tdata,
  output logic                       sm_tlast,
  input  logic                       sm_tready,
  output logic [pDATA_WIDTH/8-1:0]   tap_WE,
  output logic                       tap_EN,
  output logic [pDATA_WIDTH-1:0]     tap_Di,
  output logic [pADDR_WIDTH-1:0]     tap_A,
  input  logic [pDATA_WIDTH-1:0]     tap_Do,
  output logic [pDATA_WIDTH/8-1:0]   data_WE,
  output logic                       data_EN,
  output logic [pDATA_WIDTH-1:0]     data_Di,
  output logic [pADDR_WIDTH-1:0]     data_A,
  input  logic [pDATA_WIDTH-1:0]     data_Do
);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, MAC, OUT, DONE} state_t;
  localparam logic [pADDR_WIDTH-1:0] CTRL_A = '0;
  localparam logic [pADDR_WIDTH-1:0] LEN_A = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] TAP_LO = pADDR_WIDTH'('h20);
  localparam logic [pADDR_WIDTH-1:0] TAP_HI = pADDR_WIDTH'('h48);
  localparam logic [3:0] LAST_K = 4'(Tape_Num - 1);
  localparam logic [3:0] NK = 4'(Tape_Num);
  state_t state;
  logic ap_start, ap_done, ap_idle, last, busy;
  logic [pDATA_WIDTH-1:0] data_length, count, acc, prod;
  logic [3:0] ptr, didx, k;
  logic [1:0] rd;
  logic [pADDR_WIDTH-1:0] raddr;
  logic wr_hs, ar_hs, aw_tap, ar_tap, r_tap, tap_w;
  logic unused_tlast;
  assign unused_tlast = ss_tlast;
  assign busy = state != IDLE;
  assign wr_hs = awvalid & wvalid & !axis_rst;
  assign awready = wr_hs;
  assign wready = wr_hs;
  assign aw_tap = awaddr >= TAP_LO && awaddr <= TAP_HI;
  assign ar_tap = araddr >= TAP_LO && araddr <= TAP_HI;
  assign r_tap = raddr >= TAP_LO && raddr <= TAP_HI;
  assign tap_w = wr_hs & aw_tap & !busy;
  // a tap write owns the single RAM port this cycle, so a coinciding tap read waits
  assign arready = arvalid & (rd == 2'd0) & !axis_rst & !(tap_w & ar_tap);
  assign ar_hs = arvalid & arready;
  assign rvalid = rd == 2'd2;
  assign ss_tready = state == WAIT_IN;
  assign sm_tvalid = state == OUT;
  assign sm_tlast = (state == OUT) & last;
  assign prod = tap_Do * data_Do;
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = '0;
    tap_A = '0;
    tap_Di = '0;
    if (state == MAC) begin
      tap_EN = k <= LAST_K;
      tap_A = pADDR_WIDTH'({k, 2'b00});
    end else if (!busy) begin
      tap_EN = tap_w | (ar_hs & ar_tap);
      tap_WE = tap_w ? '1 : '0;
      tap_A = tap_w ? awaddr - TAP_LO : araddr - TAP_LO;
      tap_Di = wdata;
    end
  end
  always_comb begin
    data_EN = 1'b0;
    data_WE = '0;
    data_A = '0;
    data_Di = '0;
    if (state == CLEAR) begin
      data_EN = 1'b1;
      data_WE = '1;
      data_A = pADDR_WIDTH'({k, 2'b00});
    end else if (state == WAIT_IN) begin
      data_EN = ss_tvalid;
      data_WE = ss_tvalid ? '1 : '0;
      data_A = pADDR_WIDTH'({ptr, 2'b00});
      data_Di = ss_tdata;
    end else if (state == MAC) begin
      data_EN = k <= LAST_K;
      data_A = pADDR_WIDTH'({didx, 2'b00});
    end
  end
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state <= IDLE;
      ap_start <= 1'b0;
      ap_done <= 1'b0;
      ap_idle <= 1'b1;
      data_length <= '0;
      count <= '0;
      acc <= '0;
      ptr <= '0;
      didx <= '0;
      k <= '0;
      last <= 1'b0;
      rd <= '0;
      raddr <= '0;
      rdata <= '0;
      sm_tdata <= '0;
    end else begin
      ap_start <= 1'b0;
      if (ar_hs) begin
        raddr <= araddr;
        rd <= 2'd1;
      end else if (rd == 2'd1) begin
        rdata <= raddr == CTRL_A ? {{(pDATA_WIDTH-3){1'b0}}, ap_idle, ap_done, ap_start & !busy} :
                 raddr == LEN_A ? data_length :
                 r_tap ? (busy ? '1 : tap_Do) : '0;
        rd <= 2'd2;
`ifdef FIR_DONE_CLEAR_ON_READ_EN
        if (raddr == CTRL_A) ap_done <= 1'b0;
`else
`endif
      end else if (rd == 2'd2 && rready) begin
        rd <= 2'd0;
      end
      if (wr_hs && !busy && awaddr == LEN_A) data_length <= wdata;
      case (state)
        IDLE: if (wr_hs && awaddr == CTRL_A && wdata[0]) begin
          ap_start <= 1'b1;
          ap_idle <= 1'b0;
          ap_done <= 1'b0;
          ptr <= '0;
          count <= '0;
          k <= '0;
          state <= data_length == '0 ? DONE : CLEAR;
        end
        CLEAR: begin
          k <= k == LAST_K ? 4'd0 : k + 4'd1;
          if (k == LAST_K) state <= WAIT_IN;
        end
        WAIT_IN: if (ss_tvalid) begin
          k <= '0;
          acc <= '0;
          didx <= ptr;
          state <= MAC;
        end
        MAC: begin
          // RAM reads land one cycle after issue, so the accumulate trails the tap index by one
          k <= k + 4'd1;
          didx <= didx == 4'd0 ? LAST_K : didx - 4'd1;
          if (k != 4'd0) acc <= acc + prod;
          if (k == NK) begin
            sm_tdata <= acc + prod;
            last <= count + 1'b1 == data_length;
            state <= OUT;
          end
        end
        OUT: if (sm_tready) begin
          ptr <= ptr == LAST_K ? 4'd0 : ptr + 4'd1;
          count <= count + 1'b1;
          state <= last ? DONE : WAIT_IN;
        end
        DONE: begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: scoreboard bench for fir_filter with behavioural tap/data RAMs
module tb_fir_filter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr, tap_A, data_A;
  logic [31:0] wdata, rdata, ss_tdata, sm_tdata, tap_Di, tap_Do, data_Di, data_Do;
  logic ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready, tap_EN, data_EN;
  logic [3:0] tap_WE, data_WE;
  int total = 0, bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  int hist[11];
  int taps[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  logic [31:0] tap_mem[16], data_mem[16];

  fir_filter dut (
    .axis_clk(clk), .axis_rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  initial for (int i = 0; i < 16; i++) begin
    tap_mem[i] = '0;
    data_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++) if (tap_WE[b]) tap_mem[tap_A[5:2]][b*8 +: 8] <= tap_Di[b*8 +: 8];
      tap_Do <= tap_mem[tap_A[5:2]];
    end
    if (data_EN) begin
      for (int b = 0; b < 4; b++) if (data_WE[b]) data_mem[data_A[5:2]][b*8 +: 8] <= data_Di[b*8 +: 8];
      data_Do <= data_mem[data_A[5:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (sm_tvalid && sm_tready) begin
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_output: got %h expected none", sm_tdata);
    end else begin
      e = exp_q.pop_front();
      check("out_data", sm_tdata, e[31:0]);
      check("out_last", {31'b0, sm_tlast}, {31'b0, e[32]});
    end
  end

  initial begin
    sm_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 sm_tready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    @(posedge clk);
    #1 arvalid = 1'b1; araddr = a;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      total++;
      bad++;
      $display("FAIL read_timeout: got no rvalid expected rvalid at addr %h", a);
    end
    d = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x);
    int n;
    ss_tvalid = 1'b1;
    ss_tdata = x;
    n = 0;
    @(negedge clk);
    while (!ss_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ss_tready) begin
      total++;
      bad++;
      $display("FAIL ss_timeout: got tready=0 expected 1");
    end
    @(posedge clk);
    #1 ss_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] d;
    int n;
    n = 0;
    axi_read(12'h000, d);
    while (d[1] !== 1'b1 && n < 300) begin
      axi_read(12'h000, d);
      n++;
    end
    check(name, d, 32'h6);
  endtask

  function automatic logic [31:0] model(input int x);
    int y;
    for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    y = 0;
    for (int i = 0; i < 11; i++) y += taps[i] * hist[i];
    return y;
  endfunction

  initial begin
    logic [31:0] d;
    int seen, x;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 1; awaddr = 0; araddr = 0; wdata = 0;
    ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    axi_read(12'h000, d);
    check("ctrl_reset", d, 32'h4);
    axi_write(12'h010, 600);
    for (int i = 0; i < 11; i++) axi_write(12'(12'h20 + 4 * i), taps[i]);
    axi_read(12'h010, d);
    check("len_readback", d, 600);
    for (int i = 0; i < 11; i++) begin
      axi_read(12'(12'h20 + 4 * i), d);
      check("tap_readback", d, taps[i]);
    end
    axi_read(12'h04c, d);
    check("unmapped_read", d, 0);
    axi_write(12'h010, 12);
    ss_tvalid = 1'b1;
    ss_tdata = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ss_tready) seen++;
    end
    check("tready_prestart", seen, 0);
    axi_write(12'h000, 1);
    fork
      for (int i = 0; i < 12; i++) begin
        exp_q.push_back({i == 11, i < 11 ? 32'(taps[i]) : 32'h0});
        send(i == 0 ? 1 : 0);
      end
      begin
        logic [31:0] d2;
        repeat (20) @(posedge clk);
        axi_read(12'h000, d2);
        check("ctrl_busy", d2 & 32'hf, 0);
        axi_write(12'h020, 99);
        axi_read(12'h024, d2);
        check("tap_busy", d2, 32'hffff_ffff);
      end
    join
    wait_done("ctrl_done_impulse");
    check("queue_empty_impulse", exp_q.size(), 0);
    axi_read(12'h020, d);
    check("tap_unchanged", d, 0);
    axi_write(12'h010, 0);
    axi_write(12'h000, 1);
    wait_done("ctrl_done_len0");
    axi_write(12'h010, 600);
    axi_write(12'h000, 1);
    for (int i = 0; i < 11; i++) hist[i] = 0;
    for (int i = 0; i < 600; i++) begin
      x = i % 50 == 7 ? 32'h7fff_ffff : i % 50 == 30 ? 32'h8000_0000 : (i * 37) % 201 - 100;
      exp_q.push_back({i == 599, model(x)});
      send(x);
    end
    wait_done("ctrl_done_full");
    check("queue_empty_full", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
